zle_param_eos: RTL and testbench

//  Parametrised zero run-length encoder with end-of-stream (EOS) flush.

---
 rtl/zle_pkg.sv | 19 +
 rtl/zle_if.sv | 13 +
 rtl/zle_out_reg.sv | 36 +++
 rtl/zle_param_eos.sv | 116 +++++++++++
 tb/tb_zle_param_eos.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/zle_pkg.sv
// Shared definitions for the zle stream blocks: FSM state encoding, token tags,
// and the maximum run length as a function of the run-counter width.
package zle_pkg;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_PEND_LIT = 2'd1,
    S_PEND_EOS = 2'd2
  } state_t;

  // Tokens are DW+1 bits wide; the tag occupies the MSB (bit DW).
  localparam logic TAG_RUN = 1'b1;
  localparam logic TAG_LIT = 1'b0;

  function automatic int unsigned zle_maxrun(input int unsigned cw);
    return (32'd1 << cw) - 32'd1;
  endfunction

endpackage

// File: rtl/zle_if.sv
// Valid/busy stream bundle. The master drives data, EOS and valid;
// the slave answers with busy.
interface zle_if #(
  parameter int W = 8
);
  logic [W-1:0] d;
  logic         e;
  logic         v;
  logic         b;

  modport master (output d, output e, output v, input b);
  modport slave  (input d, input e, input v, output b);
endinterface

// File: rtl/zle_out_reg.sv
// One-entry output holding register. It is full while q_v is high, drains on
// a transfer, and a load in the same cycle as a drain takes priority.
module zle_out_reg #(
  parameter int W = 9
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] ld_d,
  input  logic         ld_e,
  input  logic         busy,
  output logic [W-1:0] q_d,
  output logic         q_e,
  output logic         q_v,
  output logic         xfer
);

  assign xfer = q_v && !busy;

  // NOTE: sequential state is written with non-blocking assignments only, and
  // every register here is cleared by the asynchronous reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_d <= '0;
      q_e <= 1'b0;
      q_v <= 1'b0;
    end else if (load) begin
      q_d <= ld_d;
      q_e <= ld_e;
      q_v <= 1'b1;
    end else if (xfer) begin
      q_v <= 1'b0;
    end
  end

endmodule

// File: rtl/zle_param_eos.sv
// Zero run-length encoder with end-of-stream flush. Zeros collapse into run
// tokens, non-zero values pass as literals, and EOS closes any open run.
module zle_param_eos
  import zle_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 4
) (
  input  logic clock,
  input  logic reset,
  zle_if.slave  i,
  zle_if.master o
);

  localparam logic [CW-1:0] MAXRUN = CW'(zle_maxrun(CW));

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n, cnt_inc;
  logic [DW-1:0]   pend_d, pend_n;
  logic            load, ld_e, xfer, can_load, acc;
  logic [DW:0]     ld_d;

  // The output register can take a token when empty or draining this cycle.
  assign can_load = !o.v || !o.b;
  assign i.b      = !(state == S_RUN && can_load);
  assign acc      = i.v && !i.b;
  assign cnt_inc  = cnt + 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_RUN;
      cnt    <= '0;
      pend_d <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      pend_d <= pend_n;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pend_d;
    load    = 1'b0;
    ld_d    = '0;
    ld_e    = 1'b0;

    unique case (state)
      S_RUN: begin
        if (acc) begin
          if (i.e) begin
            if (cnt == '0) begin
              load = 1'b1;
              ld_e = 1'b1;
            end else begin
              load    = 1'b1;
              ld_d    = {TAG_RUN, DW'(cnt)};
              cnt_n   = '0;
              state_n = S_PEND_EOS;
            end
          end else if (i.d == '0) begin
            if (cnt_inc == MAXRUN) begin
              load  = 1'b1;
              ld_d  = {TAG_RUN, DW'(MAXRUN)};
              cnt_n = '0;
            end else begin
              cnt_n = cnt_inc;
            end
          end else if (cnt == '0) begin
            load = 1'b1;
            ld_d = {TAG_LIT, i.d};
          end else begin
            // Close the open run first; the literal waits for the next slot.
            load    = 1'b1;
            ld_d    = {TAG_RUN, DW'(cnt)};
            pend_n  = i.d;
            cnt_n   = '0;
            state_n = S_PEND_LIT;
          end
        end
      end
      S_PEND_LIT: begin
        if (xfer) begin
          load    = 1'b1;
          ld_d    = {TAG_LIT, pend_d};
          state_n = S_RUN;
        end
      end
      S_PEND_EOS: begin
        if (xfer) begin
          load    = 1'b1;
          ld_e    = 1'b1;
          state_n = S_RUN;
        end
      end
      default: state_n = S_RUN;
    endcase
  end

  zle_out_reg #(.W(DW + 1)) u_out (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .ld_d  (ld_d),
    .ld_e  (ld_e),
    .busy  (o.b),
    .q_d   (o.d),
    .q_e   (o.e),
    .q_v   (o.v),
    .xfer  (xfer)
  );

endmodule

// File: tb/tb_zle_param_eos.sv
// Self-checking bench for zle_param_eos (DW=8, CW=4): directed per-cycle
// vectors, hand-written corner sequences, then a random stream with a decoder.
module tb_zle_param_eos;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  zle_if #(.W(8)) in_if ();
  zle_if #(.W(9)) out_if ();

  zle_param_eos #(.DW(8), .CW(4)) dut (
    .clock (clock),
    .reset (reset),
    .i     (in_if),
    .o     (out_if)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       v;
    logic       e;
    logic [7:0] d;
    logic       ob;
    logic       ev;
    logic [8:0] ed;
    logic       ee;
    logic       eib;
  } vec_t;

  vec_t       tbl[14];
  logic [8:0] exp_q[$];
  logic       prev_stall;
  logic [8:0] prev_d;
  logic       prev_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive at the falling edge, then compare state before the next rise.
  task automatic step(input string name, input logic v, input logic e, input logic [7:0] d,
                      input logic ob, input logic ev, input logic [8:0] ed, input logic ee,
                      input logic eib);
    @(negedge clock);
    in_if.v  = v;
    in_if.e  = e;
    in_if.d  = d;
    out_if.b = ob;
    #1;
    check({name, "_ov"}, 32'(out_if.v), 32'(ev));
    if (ev) begin
      check({name, "_od"}, 32'(out_if.d), 32'(ed));
      check({name, "_oe"}, 32'(out_if.e), 32'(ee));
    end
    check({name, "_ib"}, 32'(in_if.b), 32'(eib));
  endtask

  task automatic push_dec(input logic [8:0] item);
    if (exp_q.size() == 0) check("decode_underflow", 32'(exp_q.size()), 32'd1);
    else check("decode", 32'(item), 32'(exp_q.pop_front()));
  endtask

  // Observe one cycle's transfers (called at negedge + 1, inputs stable).
  task automatic sample_cycle();
    logic [8:0] tok;
    if (prev_stall) begin
      check("stall_ov", 32'(out_if.v), 32'd1);
      check("stall_od", 32'({out_if.e, out_if.d}), 32'({prev_e, prev_d}));
    end
    prev_stall = out_if.v && out_if.b;
    prev_d     = out_if.d;
    prev_e     = out_if.e;
    if (out_if.v && !out_if.b) begin
      tok = out_if.d;
      if (out_if.e) push_dec(9'h100);
      else if (tok[8]) begin
        check("run_len_range", 32'(tok[7:0] >= 8'd1 && tok[7:0] <= 8'd15), 32'd1);
        for (int k = 0; k < int'(tok[7:0]); k++) push_dec(9'h000);
      end else push_dec({1'b0, tok[7:0]});
    end
    if (in_if.v && !in_if.b) exp_q.push_back(in_if.e ? 9'h100 : {1'b0, in_if.d});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic held;
    logic ok;

    //          v  e  d      ob  ev ed      ee eib
    tbl[0]  = '{1, 0, 8'h05, 0,  0, 9'h000, 0, 0};
    tbl[1]  = '{1, 0, 8'h00, 0,  1, 9'h005, 0, 0};
    tbl[2]  = '{1, 0, 8'h00, 0,  0, 9'h000, 0, 0};
    tbl[3]  = '{1, 0, 8'h07, 0,  0, 9'h000, 0, 0};
    tbl[4]  = '{0, 0, 8'h00, 0,  1, 9'h102, 0, 1};
    tbl[5]  = '{0, 0, 8'h00, 0,  1, 9'h007, 0, 0};
    tbl[6]  = '{0, 0, 8'h00, 0,  0, 9'h000, 0, 0};
    tbl[7]  = '{1, 0, 8'h00, 0,  0, 9'h000, 0, 0};
    tbl[8]  = '{1, 0, 8'h00, 0,  0, 9'h000, 0, 0};
    tbl[9]  = '{1, 1, 8'hAA, 0,  0, 9'h000, 0, 0};
    tbl[10] = '{1, 0, 8'h09, 0,  1, 9'h102, 0, 1};
    tbl[11] = '{1, 0, 8'h09, 0,  1, 9'h000, 1, 0};
    tbl[12] = '{0, 0, 8'h00, 0,  1, 9'h009, 0, 0};
    tbl[13] = '{0, 0, 8'h00, 0,  0, 9'h000, 0, 0};

    in_if.v = 1'b0; in_if.e = 1'b0; in_if.d = '0; out_if.b = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_ov", 32'(out_if.v), 32'd0);
    check("rst_od", 32'(out_if.d), 32'd0);
    check("rst_oe", 32'(out_if.e), 32'd0);
    check("rst_ib", 32'(in_if.b), 32'd0);
    reset = 1'b1;

    for (int r = 0; r < 14; r++)
      step($sformatf("vec%0d", r), tbl[r].v, tbl[r].e, tbl[r].d, tbl[r].ob,
           tbl[r].ev, tbl[r].ed, tbl[r].ee, tbl[r].eib);

    // Exactly MAXRUN zeros, then a literal.
    for (int k = 0; k < 15; k++) step("z15", 1, 0, 8'h00, 0, 0, 9'h000, 0, 0);
    step("z15_lit", 1, 0, 8'h03, 0, 1, 9'h10F, 0, 0);
    step("z15_t1",  0, 0, 8'h00, 0, 1, 9'h003, 0, 0);
    step("z15_t2",  0, 0, 8'h00, 0, 0, 9'h000, 0, 0);

    // MAXRUN+1 zeros: the extra zero starts a fresh run.
    for (int k = 0; k < 15; k++) step("z16", 1, 0, 8'h00, 0, 0, 9'h000, 0, 0);
    step("z16_16",  1, 0, 8'h00, 0, 1, 9'h10F, 0, 0);
    step("z16_lit", 1, 0, 8'h03, 0, 0, 9'h000, 0, 0);
    step("z16_t1",  0, 0, 8'h00, 0, 1, 9'h101, 0, 1);
    step("z16_t2",  0, 0, 8'h00, 0, 1, 9'h003, 0, 0);
    step("z16_t3",  0, 0, 8'h00, 0, 0, 9'h000, 0, 0);

    // Back-pressure held across a run+literal pair.
    step("bp_z",   1, 0, 8'h00, 0, 0, 9'h000, 0, 0);
    step("bp_lit", 1, 0, 8'h05, 0, 0, 9'h000, 0, 0);
    for (int k = 0; k < 5; k++) step("bp_hold", 1, 0, 8'h11, 1, 1, 9'h101, 0, 1);
    step("bp_rel1", 0, 0, 8'h00, 0, 1, 9'h101, 0, 1);
    step("bp_rel2", 0, 0, 8'h00, 0, 1, 9'h005, 0, 0);
    step("bp_rel3", 0, 0, 8'h00, 0, 0, 9'h000, 0, 0);

    // Reset while a literal is pending.
    step("rp_z",   1, 0, 8'h00, 0, 0, 9'h000, 0, 0);
    step("rp_lit", 1, 0, 8'h06, 0, 0, 9'h000, 0, 0);
    step("rp_hold", 0, 0, 8'h00, 1, 1, 9'h101, 0, 1);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("rp_async_ov", 32'(out_if.v), 32'd0);
    check("rp_async_ib", 32'(in_if.b), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    out_if.b = 1'b0;
    step("rp_a0", 1, 0, 8'h00, 0, 0, 9'h000, 0, 0);
    step("rp_a1", 1, 0, 8'h04, 0, 0, 9'h000, 0, 0);
    step("rp_a2", 0, 0, 8'h00, 0, 1, 9'h101, 0, 1);
    step("rp_a3", 0, 0, 8'h00, 0, 1, 9'h004, 0, 0);
    step("rp_a4", 0, 0, 8'h00, 0, 0, 9'h000, 0, 0);

    // Random stream with random back-pressure, checked by decoding the tokens.
    prev_stall = 1'b0;
    held = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clock);
      if (!held) begin
        in_if.v = ($urandom_range(0, 3) != 0);
        in_if.e = ($urandom_range(0, 19) == 0);
        in_if.d = ($urandom_range(0, 9) < 6) ? 8'h00 : 8'($urandom_range(1, 255));
      end
      out_if.b = ($urandom_range(0, 2) == 0);
      #1;
      held = in_if.v && in_if.b;
      sample_cycle();
    end

    // Flush with a final EOS, then drain.
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clock);
      in_if.v = 1'b1; in_if.e = 1'b1; in_if.d = 8'h00; out_if.b = 1'b0;
      #1;
      ok = !in_if.b;
      sample_cycle();
    end
    check("flush_eos_accepted", 32'(ok), 32'd1);
    for (int c = 0; c < 40 && (exp_q.size() != 0 || out_if.v); c++) begin
      @(negedge clock);
      in_if.v = 1'b0; out_if.b = 1'b0;
      #1;
      sample_cycle();
    end
    check("flush_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
